// File: rtl/phy_tx_lane_serializer_pkg.sv
// Shared types and helpers for the PHY TX lane serializer.
// Optional recirculation port is enabled by defining PHY_TX_RECIRC_EN.
package phy_tx_pkg;

    localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

    typedef enum logic {
        IDLE,
        SEND
    } txState_e;

    // Lane index width, never narrower than one bit
    function automatic int laneBits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/phy_tx_lane_serializer_if.sv
// Parallel frame input and serial symbol output bundle of the TX lane serializer.
// The serializer itself takes the slave side; the lane sources / encoder take the master side.
interface phy_tx_lane_serializer_if
    import phy_tx_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 8
);
    localparam int LW = laneBits(LANES);

    logic [LANES*DW-1:0] in_data;
    logic [LANES-1:0]    in_valid;
    logic                in_push;
    logic                in_ready;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic [LW-1:0]       out_lane;
    logic                out_sof;

    modport master (
        output in_data, in_valid, in_push,
        input  in_ready, out_data, out_valid, out_lane, out_sof
    );

    modport slave (
        input  in_data, in_valid, in_push,
        output in_ready, out_data, out_valid, out_lane, out_sof
    );

endinterface

// File: rtl/phy_tx_lane_serializer_fifo.sv
// Synchronous frame FIFO with a combinational (first-word-fall-through) read port.
// Part of the PHY TX lane serializer; see phy_tx_lane_serializer.sv for PHY_TX_RECIRC_EN.
module phy_tx_frame_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full   = (count_q == (PW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdata  = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// PHY TX lane serializer: buffers LANES-wide frames and emits them one lane per clock, lane 0 first.
// Define PHY_TX_RECIRC_EN to add the recirc_data/recirc_valid loopback outputs.
module phy_tx_lane_serializer
    import phy_tx_pkg::*;
#(
    parameter int              LANES    = 4,
    parameter int              DW       = 8,
    parameter int              DEPTH    = 4,
    parameter logic [DW-1:0]   IDLE_SYM = DW'(IDLE_SYM_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset,
    phy_tx_lane_serializer_if.slave bus,
    output logic                    overflow
`ifdef PHY_TX_RECIRC_EN
    ,
    output logic [LANES*DW-1:0]     recirc_data,
    output logic                    recirc_valid
`endif
);
    localparam int LW = laneBits(LANES);
    localparam int FW = LANES * (DW + 1);

    logic [FW-1:0]       wdata;
    logic [FW-1:0]       rdata;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                frameEnd;
    logic [LANES*DW-1:0] srcData;
    logic [LANES-1:0]    srcValid;
    logic [LW-1:0]       selLane;
    logic [DW-1:0]       laneSym;
    logic                laneVld;

    txState_e            state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [LANES*DW-1:0] frameData_q;
    logic [LANES-1:0]    frameValid_q;
    logic [DW-1:0]       outData_q, outData_d;
    logic                outValid_q, outValid_d;
    logic [LW-1:0]       outLane_q, outLane_d;
    logic                outSof_q, outSof_d;
    logic                overflow_q;

    phy_tx_frame_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // A pop always lands lane 0 of the new frame on the same edge, giving zero-gap back-to-back frames
    always_comb begin
        wdata    = {bus.in_data, bus.in_valid};
        push     = bus.in_push && !full && (|bus.in_valid);
        frameEnd = (state_q == SEND) && (lane_q == LW'(LANES - 1));
        pop      = !empty && ((state_q == IDLE) || frameEnd);
        srcData  = pop ? rdata[FW-1:LANES] : frameData_q;
        srcValid = pop ? rdata[LANES-1:0]  : frameValid_q;
        selLane  = pop ? '0 : lane_q + LW'(1);
        laneSym  = IDLE_SYM;
        laneVld  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (selLane == LW'(k)) begin
                laneVld = srcValid[k];
                laneSym = srcValid[k] ? srcData[k*DW +: DW] : IDLE_SYM;
            end
        end
        state_d    = (pop || ((state_q == SEND) && !frameEnd)) ? SEND : IDLE;
        lane_d     = (state_d == SEND) ? selLane : '0;
        outData_d  = (state_d == SEND) ? laneSym : IDLE_SYM;
        outValid_d = (state_d == SEND) && laneVld;
        outLane_d  = lane_d;
        outSof_d   = (state_d == SEND) && (selLane == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            frameData_q  <= '0;
            frameValid_q <= '0;
            outData_q    <= IDLE_SYM;
            outValid_q   <= 1'b0;
            outLane_q    <= '0;
            outSof_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLane_q  <= outLane_d;
            outSof_q   <= outSof_d;
            if (pop) begin
                frameData_q  <= rdata[FW-1:LANES];
                frameValid_q <= rdata[LANES-1:0];
            end
            if (bus.in_push && full && (|bus.in_valid)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_data  = outData_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_lane  = outLane_q;
    assign bus.out_sof   = outSof_q;
    assign overflow      = overflow_q;

`ifdef PHY_TX_RECIRC_EN
    logic [LANES*DW-1:0] recircData_d;
    logic [LANES*DW-1:0] recircData_q;
    logic                recircValid_q;

    always_comb begin
        recircData_d = '0;
        for (int k = 0; k < LANES; k++) begin
            recircData_d[k*DW +: DW] = frameValid_q[k] ? frameData_q[k*DW +: DW] : IDLE_SYM;
        end
    end

    // Snapshot the finished frame on the edge after its last lane
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recircData_q  <= '0;
            recircValid_q <= 1'b0;
        end else begin
            recircValid_q <= frameEnd;
            if (frameEnd) begin
                recircData_q <= recircData_d;
            end
        end
    end

    assign recirc_data  = recircData_q;
    assign recirc_valid = recircValid_q;
`endif

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed bench for phy_tx_lane_serializer (LANES=4, DW=8, DEPTH=4).
// Define PHY_TX_RECIRC_EN to also check the recirculation outputs.
module tb_phy_tx_lane_serializer;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic overflow;
    int   vectors;
    int   miscompares;

`ifdef PHY_TX_RECIRC_EN
    logic [LANES*DW-1:0] recircData;
    logic                recircValid;
`endif

    phy_tx_lane_serializer_if #(.LANES(LANES), .DW(DW)) bus ();

    phy_tx_lane_serializer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .overflow     (overflow)
`ifdef PHY_TX_RECIRC_EN
        ,
        .recirc_data  (recircData),
        .recirc_valid (recircValid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge, and inputs change there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] valid, input logic push);
        bus.in_data  = data;
        bus.in_valid = valid;
        bus.in_push  = push;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectSym(input string tag, input logic [7:0] d, input logic v, input logic [1:0] l, input logic s);
        checkOutput({tag, ".data"},  64'(bus.out_data),  64'(d));
        checkOutput({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        checkOutput({tag, ".lane"},  64'(bus.out_lane),  64'(l));
        checkOutput({tag, ".sof"},   64'(bus.out_sof),   64'(s));
    endtask

    task automatic expectIdle(input string tag);
        expectSym(tag, 8'hBC, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] frameA;
        logic [31:0] frameB;
        logic [31:0] fr;
        logic [7:0]  sym;
        int          s;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        applyStimulus(32'h0, 4'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        $display("[TB] reset released");

        expectIdle("rst");
        checkOutput("rst.overflow", 64'(overflow), 64'd0);
        checkOutput("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // Single full frame, lane 0 = FF
        applyStimulus(32'hCCDDEEFF, 4'hF, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        tick();
        expectSym("s1.l0", 8'hFF, 1'b1, 2'd0, 1'b1);
        tick();
        expectSym("s1.l1", 8'hEE, 1'b1, 2'd1, 1'b0);
        tick();
        expectSym("s1.l2", 8'hDD, 1'b1, 2'd2, 1'b0);
        tick();
        expectSym("s1.l3", 8'hCC, 1'b1, 2'd3, 1'b0);
        tick();
        expectIdle("s1.end");

        // Two frames pushed back to back must stream with no gap
        frameA = 32'h8899AABB;
        frameB = 32'h44332211;
        applyStimulus(frameA, 4'hF, 1'b1);
        tick();
        applyStimulus(frameB, 4'hF, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            fr  = (i < 4) ? frameA : frameB;
            sym = fr[(i % 4) * 8 +: 8];
            expectSym($sformatf("s2.sym%0d", i), sym, 1'b1, 2'(i % 4), 1'((i % 4) == 0));
        end
        tick();
        expectIdle("s2.end");

        // Only lane 2 valid: other slots carry the idle symbol
        applyStimulus(32'h55775555, 4'b0100, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        tick();
        expectSym("s3.l0", 8'hBC, 1'b0, 2'd0, 1'b1);
        tick();
        expectSym("s3.l1", 8'hBC, 1'b0, 2'd1, 1'b0);
        tick();
        expectSym("s3.l2", 8'h77, 1'b1, 2'd2, 1'b0);
        tick();
        expectSym("s3.l3", 8'hBC, 1'b0, 2'd3, 1'b0);
        tick();
        expectIdle("s3.end");
`ifdef PHY_TX_RECIRC_EN
        checkOutput("s6.recirc_data",  64'(recircData),  64'hBC77BCBC);
        checkOutput("s6.recirc_valid", 64'(recircValid), 64'd1);
        tick();
        checkOutput("s6.recirc_pulse", 64'(recircValid), 64'd0);
`endif

        // All-invalid frame is dropped silently
        applyStimulus(32'h12345678, 4'h0, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expectIdle($sformatf("s3.drop%0d", i));
        end
        checkOutput("s3.overflow", 64'(overflow), 64'd0);

        // Six pushes in six cycles: the sixth hits a full FIFO and is rejected
        for (int c = 0; c < 22; c++) begin
            if (c < 6) begin
                for (int k = 0; k < 4; k++) fr[k*8 +: 8] = 8'(16 * c + k);
                applyStimulus(fr, 4'hF, 1'b1);
            end else begin
                applyStimulus(32'h0, 4'h0, 1'b0);
            end
            tick();
            if (c == 3) checkOutput("s4.ready3", 64'(bus.in_ready), 64'd1);
            if (c == 4) checkOutput("s4.full",   64'(bus.in_ready), 64'd0);
            if (c == 4) checkOutput("s4.ovf4",   64'(overflow),     64'd0);
            if (c == 5) checkOutput("s4.ovf5",   64'(overflow),     64'd1);
            if (c == 5) checkOutput("s4.ready5", 64'(bus.in_ready), 64'd1);
            if (c >= 1 && c <= 20) begin
                s = c - 1;
                expectSym($sformatf("s4.sym%0d", s), 8'(16 * (s / 4) + (s % 4)), 1'b1, 2'(s % 4), 1'((s % 4) == 0));
            end
            if (c == 21) expectIdle("s4.end");
        end

        // Reset during lane 2 aborts the frame and flushes the queued one
        applyStimulus(32'hD3D2D1D0, 4'hF, 1'b1);
        tick();
        applyStimulus(32'hE3E2E1E0, 4'hF, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        expectSym("s5.l0", 8'hD0, 1'b1, 2'd0, 1'b1);
        tick();
        tick();
        expectSym("s5.l2", 8'hD2, 1'b1, 2'd2, 1'b0);
        reset = 1'b1;
        #1;
        expectIdle("s5.rst");
        checkOutput("s5.overflow", 64'(overflow), 64'd0);
        checkOutput("s5.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        expectIdle("s5.flushed");
        applyStimulus(32'hF3F2F1F0, 4'hF, 1'b1);
        tick();
        applyStimulus(32'h0, 4'h0, 1'b0);
        tick();
        expectSym("s5.new0", 8'hF0, 1'b1, 2'd0, 1'b1);
        tick();
        expectSym("s5.new1", 8'hF1, 1'b1, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
